skolem_sweep_checker: RTL and testbench
=======================================

Name: skolem_sweep_checker

Overview:
- Sequential stimulus driver and result collector for a generated combinational Skolem/formula netlist; the formula is the device under check.
- Walks an inclusive range of input assignments and presents each one to the formula over a valid/ready handshake.
- Collects the formula's single-bit verdict per assignment and reports pass/fail counts plus the first failing assignment.
- Sits in the result-checking harness, between the host sequencer and the formula wrapper.

Parameters:
- NUM_VARS, 31: width of the assignment vector; matches the formula's input count.
- CNT_W, 32: width of the pass and fail counters.
- TIMEOUT, 1024: cycles allowed for a verdict; used only when SKC_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; ignored while busy=1.
- stop_on_fail  in  1  sampled on the start cycle; 1 ends the sweep at the first fail verdict.
- lo_vec  in  NUM_VARS  first assignment, inclusive; sampled on the start cycle.
- hi_vec  in  NUM_VARS  last assignment, inclusive; sampled on the start cycle.
- vec_out  out  NUM_VARS  assignment presented to the formula.
- vec_valid  out  1  vec_out is valid.
- vec_ready  in  1  formula side accepts vec_out.
- res_valid  in  1  verdict is valid.
- res_bit  in  1  verdict: 1 = formula true (pass), 0 = fail.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when a sweep ends.
- fail_seen  out  1  at least one fail verdict recorded in the current/last sweep.
- first_fail  out  NUM_VARS  assignment that produced the first fail verdict.
- pass_cnt  out  CNT_W  number of pass verdicts.
- fail_cnt  out  CNT_W  number of fail verdicts.
- timeout  out  1  sweep aborted by the watchdog; present only with SKC_TIMEOUT_EN.

Behaviour:
- Reset: all outputs 0, FSM returns to IDLE. Reset mid-sweep abandons the sweep; no done pulse is issued.
- FSM states: IDLE, DRIVE, WAIT, DONE. busy=1 in DRIVE and WAIT only.
- IDLE, start=1:
  - latch cur=lo_vec, hi=hi_vec, mode=stop_on_fail;
  - clear pass_cnt, fail_cnt, fail_seen, first_fail;
  - if lo_vec > hi_vec (unsigned), go to DONE; otherwise go to DRIVE.
- DRIVE:
  - vec_valid=1, vec_out=cur; vec_out is held stable until accepted.
  - vec_valid && vec_ready moves to WAIT; vec_valid drops in WAIT.
- WAIT: res_valid is honoured only in this state and is ignored elsewhere. On res_valid:
  - res_bit=1: pass_cnt increments.
  - res_bit=0: fail_cnt increments; if fail_seen=0, latch first_fail=cur and set fail_seen=1.
  - If cur==hi, or (res_bit=0 and mode=1), go to DONE.
  - Otherwise cur increments by 1 and the FSM returns to DRIVE.
- DONE: done=1 for exactly one cycle, then IDLE. A start arriving in the DONE cycle is ignored.
- Range end: termination is by equality with hi, so the all-ones assignment is checked once and cur never wraps.
- Counters saturate at 2^CNT_W-1 rather than wrapping.
- Results (counts, fail_seen, first_fail) hold until the next accepted start.
- Throughput: 2 cycles per assignment minimum, with vec_ready held high and res_valid arriving the cycle after acceptance.
- vec_out holds its last value outside DRIVE.

Optional Feature:
- Macro: SKC_TIMEOUT_EN.
- Defined:
  - a cycle counter runs in WAIT and clears on every entry to WAIT;
  - if TIMEOUT cycles elapse without res_valid, the FSM goes to DONE and timeout=1 (held until the next start);
  - counts keep the values they had at the abort.
- Undefined: no timeout port and no counter; WAIT waits indefinitely.

Test Plan:
- Full pass sweep: lo=0, hi=7, responder always returns res_bit=1 with ready=1 -> pass_cnt=8, fail_cnt=0, fail_seen=0, done pulse 16 cycles after the first vec_valid.
- Single fail, continue: lo=0, hi=15, res_bit = (vec != 5), stop_on_fail=0 -> pass_cnt=15, fail_cnt=1, first_fail=5, fail_seen=1.
- Stop on fail: same stimulus with stop_on_fail=1 -> sweep ends after vec 5; pass_cnt=5, fail_cnt=1, vec_out never shows 6.
- Boundaries: lo=hi=2^NUM_VARS-1 gives exactly one vector and no wrap; lo=9, hi=3 gives done with no vec_valid and counts 0; start while busy has no effect.
- Backpressure and reset: vec_ready low for 3 cycles keeps vec_out stable; rst asserted in WAIT -> next cycle busy=0 and counts 0, no done pulse; a spurious res_valid in IDLE is ignored.
- With SKC_TIMEOUT_EN and TIMEOUT=4, the responder never answers vec 2 -> timeout=1, done pulse, pass_cnt=2.

Source files
------------

// File: rtl/skolem_sweep_checker.sv
// rtl/skolem_sweep_checker.sv - sweep an inclusive assignment range through a formula and tally verdicts
// Optional verdict watchdog and timeout port: define SKC_TIMEOUT_EN.
module skolem_sweep_checker #(
  parameter int NUM_VARS = 31,
  parameter int CNT_W    = 32
`ifdef SKC_TIMEOUT_EN
  ,
  parameter int TIMEOUT  = 1024
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop_on_fail,
  input  logic [NUM_VARS-1:0] lo_vec,
  input  logic [NUM_VARS-1:0] hi_vec,
  output logic [NUM_VARS-1:0] vec_out,
  output logic                vec_valid,
  input  logic                vec_ready,
  input  logic                res_valid,
  input  logic                res_bit,
  output logic                busy,
  output logic                done,
  output logic                fail_seen,
  output logic [NUM_VARS-1:0] first_fail,
`ifdef SKC_TIMEOUT_EN
  output logic                timeout,
`endif
  output logic [CNT_W-1:0]    pass_cnt,
  output logic [CNT_W-1:0]    fail_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [NUM_VARS-1:0] cur_q, cur_d;
  logic [NUM_VARS-1:0] hi_q, hi_d;
  logic [NUM_VARS-1:0] vec_q, vec_d;
  logic [NUM_VARS-1:0] ff_q, ff_d;
  logic [NUM_VARS-1:0] cur_inc;
  logic                mode_q, mode_d;
  logic                fs_q, fs_d;
  logic [CNT_W-1:0]    pass_q, pass_d;
  logic [CNT_W-1:0]    fail_q, fail_d;

`ifdef SKC_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          to_q, to_d;
`endif

  // Termination is by equality with hi, so this increment never wraps in use.
  assign cur_inc = cur_q + NUM_VARS'(1);

  // State and result registers; reset abandons any sweep without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      hi_q    <= '0;
      vec_q   <= '0;
      ff_q    <= '0;
      mode_q  <= 1'b0;
      fs_q    <= 1'b0;
      pass_q  <= '0;
      fail_q  <= '0;
`ifdef SKC_TIMEOUT_EN
      tcnt_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      hi_q    <= hi_d;
      vec_q   <= vec_d;
      ff_q    <= ff_d;
      mode_q  <= mode_d;
      fs_q    <= fs_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
`ifdef SKC_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      to_q    <= to_d;
`endif
    end
  end

  // Next-state logic: latch on start, present vectors, collect verdicts with saturating counts.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    hi_d    = hi_q;
    vec_d   = vec_q;
    ff_d    = ff_q;
    mode_d  = mode_q;
    fs_d    = fs_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
`ifdef SKC_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    to_d    = to_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d  = lo_vec;
          hi_d   = hi_vec;
          mode_d = stop_on_fail;
          pass_d = '0;
          fail_d = '0;
          fs_d   = 1'b0;
          ff_d   = '0;
`ifdef SKC_TIMEOUT_EN
          to_d   = 1'b0;
`endif
          if (lo_vec > hi_vec) begin
            state_d = S_DONE;
          end else begin
            vec_d   = lo_vec;
            state_d = S_DRIVE;
          end
        end
      end
      S_DRIVE: begin
        if (vec_ready) begin
          state_d = S_WAIT;
`ifdef SKC_TIMEOUT_EN
          tcnt_d  = '0;
`endif
        end
      end
      S_WAIT: begin
        if (res_valid) begin
          if (res_bit) begin
            if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
          end else begin
            if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
            if (!fs_q) begin
              ff_d = cur_q;
              fs_d = 1'b1;
            end
          end
          if ((cur_q == hi_q) || (!res_bit && mode_q)) begin
            state_d = S_DONE;
          end else begin
            cur_d   = cur_inc;
            vec_d   = cur_inc;
            state_d = S_DRIVE;
          end
        end
`ifdef SKC_TIMEOUT_EN
        else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          to_d    = 1'b1;
        end else begin
          tcnt_d  = tcnt_q + TW'(1);
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign vec_out    = vec_q;
  assign vec_valid  = (state_q == S_DRIVE);
  assign busy       = (state_q == S_DRIVE) || (state_q == S_WAIT);
  assign done       = (state_q == S_DONE);
  assign fail_seen  = fs_q;
  assign first_fail = ff_q;
  assign pass_cnt   = pass_q;
  assign fail_cnt   = fail_q;
`ifdef SKC_TIMEOUT_EN
  assign timeout    = to_q;
`endif

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// tb/tb_skolem_sweep_checker.sv - randomized self-checking bench for skolem_sweep_checker
module tb_skolem_sweep_checker;

  typedef logic [30:0] vq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop_on_fail = 1'b0;
  logic [30:0] lo_vec = '0;
  logic [30:0] hi_vec = '0;
  logic [30:0] vec_out;
  logic        vec_valid;
  logic        vec_ready = 1'b1;
  logic        res_valid = 1'b0;
  logic        res_bit = 1'b0;
  logic        busy;
  logic        done;
  logic        fail_seen;
  logic [30:0] first_fail;
  logic [3:0]  pass_cnt;
  logic [3:0]  fail_cnt;
`ifdef SKC_TIMEOUT_EN
  logic        timeout;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // responder configuration
  bit          fv_en = 1'b0;
  logic [30:0] fv = '0;
  int unsigned fmod = 0;
  int unsigned frem = 0;
  bit          drop_en = 1'b0;
  logic [30:0] drop_vec = '0;
  bit          force_rv = 1'b0;
  bit          force_rb = 1'b0;

  // observations from run_sweep
  vq_t         acc_q;
  int          obs_lat;
  bit          obs_done;
  bit          obs_after_idle;

  logic        hs_n = 1'b0;
  logic [30:0] hv_n = '0;

  skolem_sweep_checker #(
    .NUM_VARS(31),
    .CNT_W(4)
`ifdef SKC_TIMEOUT_EN
    , .TIMEOUT(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop_on_fail(stop_on_fail),
    .lo_vec(lo_vec), .hi_vec(hi_vec), .vec_out(vec_out), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .res_valid(res_valid), .res_bit(res_bit),
    .busy(busy), .done(done), .fail_seen(fail_seen), .first_fail(first_fail),
`ifdef SKC_TIMEOUT_EN
    .timeout(timeout),
`endif
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  function automatic bit is_fail(input logic [30:0] v);
    return (fv_en && v == fv) || (fmod != 0 && (32'(v) % fmod) == frem);
  endfunction

  // record handshakes away from the edge
  always @(negedge clk) begin
    hs_n = vec_valid && vec_ready;
    hv_n = vec_out;
    if (hs_n) acc_q.push_back(vec_out);
  end

  // formula stand-in: verdict the cycle after acceptance
  always @(posedge clk) begin
    #1;
    if (force_rv) begin
      res_valid = 1'b1;
      res_bit   = force_rb;
    end else if (hs_n && !(drop_en && hv_n == drop_vec)) begin
      res_valid = 1'b1;
      res_bit   = !is_fail(hv_n);
    end else begin
      res_valid = 1'b0;
      res_bit   = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // reference: walk lo..hi inclusively with wide arithmetic
  task automatic model(input logic [30:0] lo, input logic [30:0] hi, input bit stop,
                       output int pc, output int fc, output bit fs,
                       output logic [30:0] ff, output vq_t seq);
    bit f;
    pc = 0; fc = 0; fs = 0; ff = '0;
    seq.delete();
    for (longint v = longint'(lo); v <= longint'(hi); v++) begin
      seq.push_back(v[30:0]);
      f = is_fail(v[30:0]);
      if (f) begin
        fc = (fc < 15) ? fc + 1 : 15;
        if (!fs) begin fs = 1; ff = v[30:0]; end
        if (stop) break;
      end else begin
        pc = (pc < 15) ? pc + 1 : 15;
      end
    end
  endtask

  task automatic run_sweep(input logic [30:0] lo, input logic [30:0] hi, input bit stop,
                           input bit rnd_ready, input bit poke, input bit start_in_done);
    int first_v;
    bit b1;
    first_v = -1;
    obs_done = 0;
    obs_lat = -1;
    acc_q.delete();
    lo_vec = lo; hi_vec = hi; stop_on_fail = stop; start = 1'b1; vec_ready = 1'b1;
    tick;
    start = 1'b0;
    for (int t = 0; t < 2000 && !obs_done; t++) begin
      if (vec_valid && first_v < 0) first_v = t;
      if (done) begin
        obs_done = 1;
        obs_lat = (first_v < 0) ? -1 : t - first_v;
      end else begin
        if (poke && t == 3) begin
          start = 1'b1; lo_vec = lo + 31'd7; hi_vec = hi + 31'd20; stop_on_fail = !stop;
        end else begin
          start = 1'b0;
        end
        vec_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        tick;
      end
    end
    vec_ready = 1'b1;
    start = start_in_done;
    lo_vec = 31'd0; hi_vec = 31'd3;
    tick;
    start = 1'b0;
    b1 = busy;
    tick;
    obs_after_idle = !b1 && !busy && !done;
    n_tests++;
    if (!obs_done) begin
      n_fail++;
      $display("FAIL sweep_done_timeout: done=0 required=1");
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    n_tests++;
    if ({busy, done, vec_valid, fail_seen, vec_out, first_fail, pass_cnt, fail_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%0b done=%0b vv=%0b fs=%0b vec=%0h ff=%0h pc=%0d fc=%0d required all 0",
               busy, done, vec_valid, fail_seen, vec_out, first_fail, pass_cnt, fail_cnt);
    end
`ifdef SKC_TIMEOUT_EN
    n_tests++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got=%0b required=0", timeout); end
`endif
  endtask

  task automatic test_full_pass;
    fv_en = 0; fmod = 0;
    run_sweep(31'd0, 31'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (pass_cnt !== 4'd8 || fail_cnt !== 4'd0 || fail_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pass_counts: pc=%0d fc=%0d fs=%0b required 8 0 0", pass_cnt, fail_cnt, fail_seen);
    end
    n_tests++;
    if (obs_lat !== 16) begin n_fail++; $display("FAIL full_pass_latency: got=%0d required=16", obs_lat); end
    n_tests++;
    if (!obs_after_idle) begin n_fail++; $display("FAIL full_pass_single_done: extra busy/done after pulse, required idle"); end
`ifdef SKC_TIMEOUT_EN
    n_tests++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL full_pass_timeout: got=%0b required=0", timeout); end
`endif
  endtask

  task automatic test_single_fail(input bit stop);
    bit six;
    fv_en = 1; fv = 31'd5; fmod = 0;
    run_sweep(31'd0, 31'd15, stop, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (stop) begin
      if (pass_cnt !== 4'd5 || fail_cnt !== 4'd1 || first_fail !== 31'd5 || fail_seen !== 1'b1) begin
        n_fail++;
        $display("FAIL stop_on_fail: pc=%0d fc=%0d ff=%0d fs=%0b required 5 1 5 1", pass_cnt, fail_cnt, first_fail, fail_seen);
      end
      six = 0;
      foreach (acc_q[i]) if (acc_q[i] == 31'd6) six = 1;
      n_tests++;
      if (six) begin n_fail++; $display("FAIL stop_no_vec6: vec 6 presented=1 required=0"); end
    end else begin
      if (pass_cnt !== 4'd15 || fail_cnt !== 4'd1 || first_fail !== 31'd5 || fail_seen !== 1'b1) begin
        n_fail++;
        $display("FAIL single_fail: pc=%0d fc=%0d ff=%0d fs=%0b required 15 1 5 1", pass_cnt, fail_cnt, first_fail, fail_seen);
      end
    end
    fv_en = 0;
  endtask

  task automatic test_boundaries;
    int pc, fc; bit fs; logic [30:0] ff; vq_t seq;
    fv_en = 0; fmod = 0;
    run_sweep(31'h7fffffff, 31'h7fffffff, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (acc_q.size() != 1 || pass_cnt !== 4'd1 || fail_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL all_ones_single: nvec=%0d pc=%0d fc=%0d required 1 1 0", acc_q.size(), pass_cnt, fail_cnt);
    end
    fmod = 2; frem = 0;
    run_sweep(31'd9, 31'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    n_tests++;
    if (obs_lat != -1 || acc_q.size() != 0 || pass_cnt !== 4'd0 || fail_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL empty_range: lat=%0d nvec=%0d pc=%0d fc=%0d required -1 0 0 0", obs_lat, acc_q.size(), pass_cnt, fail_cnt);
    end
    n_tests++;
    if (!obs_after_idle) begin n_fail++; $display("FAIL start_in_done: busy after start in done cycle, required idle"); end
    fmod = 3; frem = 1;
    run_sweep(31'd20, 31'd30, 1'b0, 1'b0, 1'b1, 1'b0);
    model(31'd20, 31'd30, 1'b0, pc, fc, fs, ff, seq);
    n_tests++;
    if (acc_q != seq || pass_cnt !== 4'(pc) || fail_cnt !== 4'(fc) || first_fail !== ff) begin
      n_fail++;
      $display("FAIL start_while_busy: nvec=%0d pc=%0d fc=%0d ff=%0d required nvec=%0d pc=%0d fc=%0d ff=%0d",
               acc_q.size(), pass_cnt, fail_cnt, first_fail, seq.size(), pc, fc, ff);
    end
    fmod = 0;
  endtask

  task automatic test_saturation;
    fv_en = 0; fmod = 0;
    run_sweep(31'd0, 31'd19, 1'b0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (pass_cnt !== 4'd15 || acc_q.size() != 20) begin
      n_fail++;
      $display("FAIL saturation: pc=%0d nvec=%0d required 15 20", pass_cnt, acc_q.size());
    end
  endtask

  task automatic test_random;
    int pc, fc; bit fs; logic [30:0] ff; vq_t seq;
    logic [30:0] lo, hi; int span; bit stop;
    for (int it = 0; it < 20; it++) begin
      span = $urandom_range(0, 12);
      lo = (it % 5 == 4) ? 31'h7fffffff - 31'(span) : 31'($urandom_range(0, 32'h7ffffff0));
      hi = lo + 31'(span);
      if ($urandom_range(0, 7) == 0) begin logic [30:0] tmp; tmp = lo; lo = hi + 31'd1; hi = tmp; end
      stop = $urandom_range(0, 1);
      fv_en = $urandom_range(0, 1); fv = lo + 31'($urandom_range(0, 12));
      fmod = $urandom_range(3, 9); frem = $urandom_range(0, fmod - 1);
      run_sweep(lo, hi, stop, 1'b1, 1'b0, 1'b0);
      model(lo, hi, stop, pc, fc, fs, ff, seq);
      n_tests++;
      if (acc_q != seq || pass_cnt !== 4'(pc) || fail_cnt !== 4'(fc) || fail_seen !== fs || (fs && first_fail !== ff)) begin
        n_fail++;
        $display("FAIL random_%0d: lo=%0h hi=%0h nvec=%0d pc=%0d fc=%0d fs=%0b ff=%0h required nvec=%0d pc=%0d fc=%0d fs=%0b ff=%0h",
                 it, lo, hi, acc_q.size(), pass_cnt, fail_cnt, fail_seen, first_fail, seq.size(), pc, fc, fs, ff);
      end
    end
    fv_en = 0; fmod = 0;
  endtask

  task automatic test_backpressure;
    bit stable; bit seen;
    fv_en = 0; fmod = 0;
    acc_q.delete();
    lo_vec = 31'd100; hi_vec = 31'd101; stop_on_fail = 0; vec_ready = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    stable = 1;
    for (int i = 0; i < 4; i++) begin
      if (!(vec_valid === 1'b1 && vec_out === 31'd100)) stable = 0;
      if (i < 3) tick;
    end
    n_tests++;
    if (!stable) begin n_fail++; $display("FAIL backpressure_hold: vv=%0b vec=%0d required 1 100", vec_valid, vec_out); end
    vec_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (done) seen = 1; else tick;
    end
    n_tests++;
    if (!seen || pass_cnt !== 4'd2 || acc_q.size() != 2) begin
      n_fail++;
      $display("FAIL backpressure_result: done=%0b pc=%0d nvec=%0d required 1 2 2", seen, pass_cnt, acc_q.size());
    end
    tick;
  endtask

  task automatic test_reset_mid;
    bit reached; bit any_done;
    fv_en = 0; fmod = 0;
    acc_q.delete();
    lo_vec = 31'd0; hi_vec = 31'd15; stop_on_fail = 0; vec_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    reached = 0;
    for (int i = 0; i < 100 && !reached; i++) begin
      if (acc_q.size() >= 3 && busy && !vec_valid) reached = 1; else tick;
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_tests++;
    if (!reached || busy !== 1'b0 || pass_cnt !== 4'd0 || fail_cnt !== 4'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_wait: reached=%0b busy=%0b pc=%0d fc=%0d done=%0b required 1 0 0 0 0",
               reached, busy, pass_cnt, fail_cnt, done);
    end
    any_done = 0;
    for (int i = 0; i < 5; i++) begin tick; if (done || busy) any_done = 1; end
    n_tests++;
    if (any_done) begin n_fail++; $display("FAIL reset_no_done: done/busy after reset=1 required=0"); end
  endtask

  task automatic test_spurious;
    fv_en = 1; fv = 31'd1; fmod = 0;
    run_sweep(31'd0, 31'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    force_rv = 1; force_rb = 0;
    tick; tick; tick;
    force_rv = 0;
    tick; tick;
    n_tests++;
    if (pass_cnt !== 4'd3 || fail_cnt !== 4'd1 || first_fail !== 31'd1 || busy !== 1'b0 || fail_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL spurious_res_idle: pc=%0d fc=%0d ff=%0d busy=%0b fs=%0b required 3 1 1 0 1",
               pass_cnt, fail_cnt, first_fail, busy, fail_seen);
    end
    fv_en = 0;
  endtask

`ifdef SKC_TIMEOUT_EN
  task automatic test_timeout;
    fv_en = 0; fmod = 0;
    drop_en = 1; drop_vec = 31'd2;
    run_sweep(31'd0, 31'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    drop_en = 0;
    n_tests++;
    if (timeout !== 1'b1 || pass_cnt !== 4'd2 || fail_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL timeout_abort: to=%0b pc=%0d fc=%0d required 1 2 0", timeout, pass_cnt, fail_cnt);
    end
  endtask
`endif

  initial begin
    test_reset;
`ifdef SKC_TIMEOUT_EN
    test_timeout;
`endif
    test_full_pass;
    test_single_fail(1'b0);
    test_single_fail(1'b1);
    test_boundaries;
    test_saturation;
    test_backpressure;
    test_reset_mid;
    test_spurious;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
